// File: rtl/harvard_data_responder_if.sv
// CPU data-port and data-SRAM signal bundle for harvard_data_responder.
// The slave view belongs to the responder; the master view belongs to the CPU/SRAM side.
interface harvard_data_responder_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  clk_enable_in;
  logic                  cpu_clk_enable;
  logic [31:0]           data_address;
  logic                  data_read;
  logic                  data_write;
  logic [31:0]           data_writedata;
  logic [31:0]           data_readdata;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic                  sram_en;
  logic                  sram_we;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_rdata;
  logic                  err;

  modport slave (
    input  clk_enable_in, data_address, data_read, data_write, data_writedata, sram_rdata,
    output cpu_clk_enable, data_readdata, sram_addr, sram_en, sram_we, sram_wdata, err
  );

  modport master (
    output clk_enable_in, data_address, data_read, data_write, data_writedata, sram_rdata,
    input  cpu_clk_enable, data_readdata, sram_addr, sram_en, sram_we, sram_wdata, err
  );
endinterface

// File: rtl/harvard_data_responder.sv
// Bridges the combinational-read MIPS data port onto a synchronous-read word SRAM,
// stalling the CPU for one cycle on every in-range load.
module harvard_data_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic                      clk,
  input logic                      reset,
  harvard_data_responder_if.slave  bus
);

  typedef enum logic {IDLE, RWAIT} state_t;

  state_t                state_q, state_d;
  logic [31:0]           hold_q, hold_d;
  logic                  fresh_q, fresh_d;
  logic                  err_q, err_d;

  logic [31:0]           offset;
  logic                  inRange;
  logic [ADDR_WIDTH-1:0] wordIdx;

  // Below-base addresses wrap to huge offsets, so both tests are needed.
  assign offset  = bus.data_address - BASE_ADDR;
  assign inRange = (bus.data_address >= BASE_ADDR) && ((offset >> (ADDR_WIDTH + 2)) == 32'd0);
  assign wordIdx = offset[ADDR_WIDTH+1:2];

  assign bus.err = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      fresh_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      fresh_q <= fresh_d;
      err_q   <= err_d;
    end
  end

  // fresh_q marks the single cycle in which sram_rdata is valid; later frozen cycles replay hold_q.
  always_comb begin
    state_d            = state_q;
    hold_d             = hold_q;
    fresh_d            = 1'b0;
    err_d              = err_q;
    bus.cpu_clk_enable = bus.clk_enable_in;
    bus.data_readdata  = '0;
    bus.sram_en        = 1'b0;
    bus.sram_we        = 1'b0;
    bus.sram_addr      = wordIdx;
    bus.sram_wdata     = bus.data_writedata;

    if (reset) begin
      case (state_q)
        IDLE: begin
          if (bus.data_write) begin
            if (inRange) begin
              bus.sram_en = bus.clk_enable_in;
              bus.sram_we = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            if (bus.data_read) begin
              err_d = 1'b1;
            end
          end else if (bus.data_read) begin
            if (inRange) begin
              bus.sram_en        = 1'b1;
              bus.cpu_clk_enable = 1'b0;
              state_d            = RWAIT;
              fresh_d            = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        RWAIT: begin
          if (fresh_q) begin
            bus.data_readdata = bus.sram_rdata;
            hold_d            = bus.sram_rdata;
          end else begin
            bus.data_readdata = hold_q;
          end
          if (bus.clk_enable_in) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_harvard_data_responder.sv
// Directed bench for harvard_data_responder: an SRAM model plus a transaction-level
// reference (memory image, pending load, sticky error) checked every cycle.
module tb_harvard_data_responder;

  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int compared    = 0;
  int mismatched  = 0;
  int stallCount  = 0;
  int writeCount  = 0;
  int cycleNo     = 0;

  always #5 clk = ~clk;

  harvard_data_responder_if #(.ADDR_WIDTH(AW)) bus ();

  harvard_data_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous-read SRAM; rdata turns to garbage whenever the previous edge was not a read.
  logic [31:0] sramMem [DEPTH];

  always @(posedge clk) begin
    cycleNo <= cycleNo + 1;
    if (bus.sram_en && bus.sram_we) begin
      sramMem[bus.sram_addr] <= bus.sram_wdata;
      writeCount             <= writeCount + 1;
    end
    if (bus.sram_en && !bus.sram_we) begin
      bus.sram_rdata <= sramMem[bus.sram_addr];
    end else begin
      bus.sram_rdata <= 32'hBAD0_0000 | {16'h0, cycleNo[15:0]};
    end
  end

  // Reference: what the CPU should see, in terms of addresses and memory contents only.
  logic [31:0] refMem [DEPTH];
  bit          pending = 1'b0;
  int          pendIdx = 0;
  bit          errExp  = 1'b0;

  function automatic bit inRangeOf(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(4 * DEPTH));
  endfunction

  function automatic int idxOf(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      errExp  <= 1'b0;
    end else if (pending) begin
      if (bus.clk_enable_in) pending <= 1'b0;
    end else if (bus.data_write) begin
      if (bus.data_read || !inRangeOf(bus.data_address)) errExp <= 1'b1;
      if (inRangeOf(bus.data_address) && bus.clk_enable_in)
        refMem[idxOf(bus.data_address)] <= bus.data_writedata;
    end else if (bus.data_read) begin
      if (inRangeOf(bus.data_address)) begin
        pending <= 1'b1;
        pendIdx <= idxOf(bus.data_address);
      end else begin
        errExp <= 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin : compareProc
    logic        expEn;
    logic        expCke;
    logic        chkRd;
    logic [31:0] expRd;
    expEn  = 1'b0;
    expCke = bus.clk_enable_in;
    expRd  = 32'h0;
    chkRd  = 1'b1;
    if (reset) begin
      if (bus.clk_enable_in && !bus.cpu_clk_enable) stallCount++;
      if (pending) begin
        expRd = refMem[pendIdx];
      end else if (bus.data_write) begin
        expEn = inRangeOf(bus.data_address) && bus.clk_enable_in;
        if (expEn) begin
          checkOutput("sram_addr(wr)", 32'(bus.sram_addr), 32'(idxOf(bus.data_address)));
          checkOutput("sram_we(wr)", 32'(bus.sram_we), 32'd1);
          checkOutput("sram_wdata", bus.sram_wdata, bus.data_writedata);
        end
      end else if (bus.data_read && inRangeOf(bus.data_address)) begin
        expEn  = 1'b1;
        expCke = 1'b0;
        chkRd  = 1'b0;
        checkOutput("sram_addr(rd)", 32'(bus.sram_addr), 32'(idxOf(bus.data_address)));
        checkOutput("sram_we(rd)", 32'(bus.sram_we), 32'd0);
      end
    end
    checkOutput("sram_en", 32'(bus.sram_en), 32'(expEn));
    checkOutput("cpu_clk_enable", 32'(bus.cpu_clk_enable), 32'(expCke));
    if (chkRd) checkOutput("data_readdata", bus.data_readdata, expRd);
    checkOutput("err", 32'(bus.err), 32'(errExp));
  end

  task automatic applyStimulus(input logic rst, input logic cke, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk);
    #2;
    reset              = rst;
    bus.clk_enable_in  = cke;
    bus.data_read      = rd;
    bus.data_write     = wr;
    bus.data_address   = addr;
    bus.data_writedata = wdata;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wcBefore;
    bus.clk_enable_in  = 1'b1;
    bus.data_read      = 1'b0;
    bus.data_write     = 1'b0;
    bus.data_address   = 32'h0;
    bus.data_writedata = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      sramMem[i] <= 32'h1000_0000 + 32'(i);
      refMem[i]  <= 32'h1000_0000 + 32'(i);
    end
    sramMem[64] <= 32'hDEADBEEF;
    refMem[64]  <= 32'hDEADBEEF;

    // Reset held with a load pending on the bus
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    settle();
    checkOutput("reset sram_en", 32'(bus.sram_en), 32'd0);
    checkOutput("reset cke", 32'(bus.cpu_clk_enable), 32'd1);
    checkOutput("reset readdata", bus.data_readdata, 32'h0);
    checkOutput("reset err", 32'(bus.err), 32'd0);

    // Release: first load issued immediately
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    settle();
    checkOutput("load issue en", 32'(bus.sram_en), 32'd1);
    checkOutput("load issue stall", 32'(bus.cpu_clk_enable), 32'd0);
    checkOutput("load issue addr", 32'(bus.sram_addr), 32'h40);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    settle();
    checkOutput("load data", bus.data_readdata, 32'hDEADBEEF);
    checkOutput("load cke", 32'(bus.cpu_clk_enable), 32'd1);

    // Store then load same word
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h12345678);
    settle();
    checkOutput("store no stall", 32'(bus.cpu_clk_enable), 32'd1);
    checkOutput("store we", 32'(bus.sram_we), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
    settle();
    checkOutput("store-load data", bus.data_readdata, 32'h12345678);

    // Out-of-range load
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h1000, 32'h0);
    settle();
    checkOutput("oor readdata", bus.data_readdata, 32'h0);
    checkOutput("oor no stall", 32'(bus.cpu_clk_enable), 32'd1);
    checkOutput("oor no access", 32'(bus.sram_en), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    checkOutput("oor err", 32'(bus.err), 32'd1);

    // Clear err, then read+write conflict
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    checkOutput("err cleared", 32'(bus.err), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'hCAFEF00D);
    settle();
    checkOutput("conflict en", 32'(bus.sram_en), 32'd1);
    checkOutput("conflict we", 32'(bus.sram_we), 32'd1);
    checkOutput("conflict no stall", 32'(bus.cpu_clk_enable), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    checkOutput("conflict err", 32'(bus.err), 32'd1);

    // Back-to-back loads
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
    settle();
    checkOutput("b2b second data", bus.data_readdata, 32'h12345678);

    // Frozen CPU during RWAIT
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    settle();
    checkOutput("frozen load held", bus.data_readdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    settle();
    checkOutput("frozen load release", bus.data_readdata, 32'hDEADBEEF);

    // Frozen CPU during a store
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    wcBefore = writeCount;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h10C, 32'h55AA55AA);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h10C, 32'h55AA55AA);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    checkOutput("frozen store count", 32'(writeCount - wcBefore), 32'd1);

    // Reset asserted mid-load
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midreset en", 32'(bus.sram_en), 32'd0);
    checkOutput("midreset cke", 32'(bus.cpu_clk_enable), 32'd1);
    checkOutput("midreset readdata", bus.data_readdata, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    checkOutput("midreset cke follows", 32'(bus.cpu_clk_enable), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    checkOutput("post-reset idle en", 32'(bus.sram_en), 32'd0);

    // Final memory image and stall accounting
    checkOutput("mem[0x41]", sramMem[65], 32'h12345678);
    checkOutput("mem[0x02]", sramMem[2], 32'hCAFEF00D);
    checkOutput("mem[0x43]", sramMem[67], 32'h55AA55AA);
    checkOutput("mem[0x40]", sramMem[64], 32'hDEADBEEF);
    checkOutput("stall cycles", 32'(stallCount), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
